// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/decode/execute control sequencer for the accumulator CPU.
// Produces a Moore micro-code word from the state register and the opcode
// captured in DEC, stalls memory states until mem_ready, and counts retired
// instructions.
module micro_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic [12:0]         micro_code,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  // Micro-operation bits
  localparam logic [12:0] MC_AR_DR_PC = 13'h1000; // AR<-DR, PC++
  localparam logic [12:0] MC_IR_DR    = 13'h0800; // IR<-DR
  localparam logic [12:0] MC_AC_DR    = 13'h0400; // AC<-DR
  localparam logic [12:0] MC_WR_MEM   = 13'h0200; // M[AR]<-DR
  localparam logic [12:0] MC_PC_DR    = 13'h0100; // PC<-DR
  localparam logic [12:0] MC_PC_DR_Z  = 13'h0080; // PC<-DR if Z
  localparam logic [12:0] MC_RD_MEM   = 13'h0040; // DR<-M[AR]
  localparam logic [12:0] MC_AR_PC    = 13'h0020; // AR<-PC
  localparam logic [12:0] MC_DR_AC    = 13'h0008; // DR<-AC
  localparam logic [12:0] MC_ADD      = 13'h0004; // AC<-AC+DR
  localparam logic [12:0] MC_SUB      = 13'h0002; // AC<-AC-DR

  // Opcodes; anything above OP_HALT is undefined and behaves as NOP
  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(7);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_DEC  = 3'd4,
    S_E0   = 3'd5,
    S_E1   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                retire;

  // State, latched opcode and retired counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  // Next-state, retire strobe and Moore micro-code decode
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    retire     = 1'b0;
    micro_code = '0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_F0;
      end

      S_F0: begin
        micro_code = MC_AR_PC;
        state_d    = S_F1;
      end

      S_F1: begin
        micro_code = MC_RD_MEM;
        if (mem_ready) state_d = S_F2;
      end

      S_F2: begin
        micro_code = MC_IR_DR | MC_AR_DR_PC;
        state_d    = S_DEC;
      end

      S_DEC: begin
        // IR is valid here; capture the opcode so E0/E1 ignore later changes
        opcode_d = ir_opcode;
        if (ir_opcode > OP_HALT) begin
          illegal_op = 1'b1;
          retire     = 1'b1;
          state_d    = S_F0;
        end else if (ir_opcode == OP_NOP) begin
          retire  = 1'b1;
          state_d = S_F0;
        end else if (ir_opcode == OP_HALT) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_E0;
        end
      end

      S_E0: begin
        case (opcode_q)
          OP_LOAD, OP_ADD, OP_SUB: begin
            micro_code = MC_RD_MEM;
            if (mem_ready) state_d = S_E1;
          end
          OP_STORE: begin
            micro_code = MC_DR_AC;
            state_d    = S_E1;
          end
          OP_JUMP: begin
            micro_code = MC_PC_DR;
            retire     = 1'b1;
            state_d    = S_F0;
          end
          OP_JZ: begin
            micro_code = MC_PC_DR_Z;
            retire     = 1'b1;
            state_d    = S_F0;
          end
          default: begin
            // Not reachable from DEC; recover to fetch
            retire  = 1'b1;
            state_d = S_F0;
          end
        endcase
      end

      S_E1: begin
        retire  = 1'b1;
        state_d = S_F0;
        case (opcode_q)
          OP_LOAD: micro_code = MC_AC_DR;
          OP_ADD:  micro_code = MC_ADD;
          OP_SUB:  micro_code = MC_SUB;
          OP_STORE: begin
            micro_code = MC_WR_MEM;
            if (!mem_ready) begin
              retire  = 1'b0;
              state_d = S_E1;
            end
          end
          default: micro_code = '0;
        endcase
      end

      S_HALT: begin
        if (start) state_d = S_F0;
      end

      default: state_d = S_IDLE;
    endcase

    count_d = count_q + CNT_W'(retire);
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer. Outputs are sampled on the falling
// edge; inputs change on the falling edge, away from the active rising edge.
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ir_opcode;
  logic        mem_ready;
  logic [12:0] micro_code;
  logic        busy;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;

  // Narrow-counter copy sharing the same stimulus, used to reach counter wrap
  logic [12:0] micro_code_w;
  logic        busy_w;
  logic        halted_w;
  logic        illegal_w;
  logic [2:0]  count_w;

  int total = 0;
  int bad   = 0;

  micro_sequencer #(.OPCODE_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir_opcode(ir_opcode),
    .mem_ready(mem_ready), .micro_code(micro_code), .busy(busy),
    .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  micro_sequencer #(.OPCODE_W(4), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .ir_opcode(ir_opcode),
    .mem_ready(mem_ready), .micro_code(micro_code_w), .busy(busy_w),
    .halted(halted_w), .illegal_op(illegal_w), .instr_count(count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset, then pulse start with the given opcode presented; returns in F0
  task automatic launch(input logic [3:0] op);
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b1; ir_opcode = op;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_opcode = 4'd0;
    #1;
    total++;
    if (micro_code !== 13'h000 || busy !== 1'b0 || instr_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_asserted: micro_code=%h busy=%b count=%h required 000/0/0000",
               micro_code, busy, instr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (micro_code !== 13'h000 || busy !== 1'b0 || halted !== 1'b0 ||
          illegal_op !== 1'b0 || instr_count !== 16'h0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: micro_code=%h busy=%b halted=%b ill=%b count=%h required 000/0/0/0/0000",
                 i, micro_code, busy, halted, illegal_op, instr_count);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_load;
    logic [12:0] exp [7];
    exp = '{13'h0020, 13'h0040, 13'h1800, 13'h0000, 13'h0040, 13'h0400, 13'h0020};
    launch(4'd1);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (micro_code !== exp[i]) begin
        bad++;
        $display("FAIL load_seq[%0d]: micro_code=%h required %h", i, micro_code, exp[i]);
      end
      // Opcode changes after DEC must not affect the running LOAD
      if (i == 4) ir_opcode = 4'd2;
      if (i < 6) @(negedge clk);
    end
    total++;
    if (instr_count !== 16'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_count: count=%0d busy=%b required 1/1", instr_count, busy);
    end
    $display("test_load done");
  endtask

  task automatic test_store_stall;
    launch(4'd2);
    repeat (4) @(negedge clk);
    total++;
    if (micro_code !== 13'h0008) begin
      bad++;
      $display("FAIL store_e0: micro_code=%h required 0008", micro_code);
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (micro_code !== 13'h0200 || instr_count !== 16'd0) begin
        bad++;
        $display("FAIL store_e1_hold[%0d]: micro_code=%h count=%0d required 0200/0", k, micro_code, instr_count);
      end
      if (k == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0020 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL store_done: micro_code=%h count=%0d required 0020/1", micro_code, instr_count);
    end
    $display("test_store_stall done");
  endtask

  task automatic test_add_sub;
    // ADD with a two-cycle F1 stall
    launch(4'd3);
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (micro_code !== 13'h0040) begin
        bad++;
        $display("FAIL add_f1_hold[%0d]: micro_code=%h required 0040", k, micro_code);
      end
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (micro_code !== 13'h0040) begin
      bad++;
      $display("FAIL add_e0: micro_code=%h required 0040", micro_code);
    end
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0004) begin
      bad++;
      $display("FAIL add_e1: micro_code=%h required 0004", micro_code);
    end
    // SUB
    launch(4'd4);
    repeat (5) @(negedge clk);
    total++;
    if (micro_code !== 13'h0002) begin
      bad++;
      $display("FAIL sub_e1: micro_code=%h required 0002", micro_code);
    end
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0020 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL sub_done: micro_code=%h count=%0d required 0020/1", micro_code, instr_count);
    end
    $display("test_add_sub done");
  endtask

  task automatic test_illegal;
    logic [3:0] exp_ill;
    exp_ill = 4'b1000; // high only in DEC (index 3)
    launch(4'd9);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (illegal_op !== exp_ill[i % 4] || (i == 4 && illegal_op !== 1'b0)) begin
        bad++;
        $display("FAIL illegal_pulse[%0d]: illegal_op=%b required %b", i, illegal_op, (i == 3));
      end
      if (i < 4) @(negedge clk);
    end
    total++;
    if (micro_code !== 13'h0020 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL illegal_next: micro_code=%h count=%0d required 0020/1", micro_code, instr_count);
    end
    $display("test_illegal done");
  endtask

  task automatic test_halt_jumps;
    launch(4'd7);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_dec: busy=%b halted=%b required 1/0", busy, halted);
    end
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || micro_code !== 13'h0 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL halt_enter: halted=%b busy=%b micro_code=%h count=%0d required 1/0/0000/1",
               halted, busy, micro_code, instr_count);
    end
    mem_ready = 1'b0; ir_opcode = 4'd1;
    repeat (2) @(negedge clk);
    total++;
    if (halted !== 1'b1 || micro_code !== 13'h0) begin
      bad++;
      $display("FAIL halt_hold: halted=%b micro_code=%h required 1/0000", halted, micro_code);
    end
    mem_ready = 1'b1; ir_opcode = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (micro_code !== 13'h0020 || busy !== 1'b1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_resume: micro_code=%h busy=%b halted=%b required 0020/1/0", micro_code, busy, halted);
    end
    @(negedge clk);
    start = 1'b1; // ignored while running
    @(negedge clk);
    start = 1'b0;
    total++;
    if (micro_code !== 13'h1800) begin
      bad++;
      $display("FAIL start_ignored: micro_code=%h required 1800", micro_code);
    end
    repeat (2) @(negedge clk);
    total++;
    if (micro_code !== 13'h0080) begin
      bad++;
      $display("FAIL jz_e0: micro_code=%h required 0080", micro_code);
    end
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0020 || instr_count !== 16'd2) begin
      bad++;
      $display("FAIL jz_done: micro_code=%h count=%0d required 0020/2", micro_code, instr_count);
    end
    ir_opcode = 4'd5;
    repeat (4) @(negedge clk);
    total++;
    if (micro_code !== 13'h0100) begin
      bad++;
      $display("FAIL jump_e0: micro_code=%h required 0100", micro_code);
    end
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0020 || instr_count !== 16'd3) begin
      bad++;
      $display("FAIL jump_done: micro_code=%h count=%0d required 0020/3", micro_code, instr_count);
    end
    $display("test_halt_jumps done");
  endtask

  task automatic test_reset_mid;
    launch(4'd0);
    repeat (4) @(negedge clk);
    total++;
    if (instr_count !== 16'd1) begin
      bad++;
      $display("FAIL mid_pre_count: count=%0d required 1", instr_count);
    end
    ir_opcode = 4'd1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (micro_code !== 13'h0040 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_e0_stall: micro_code=%h busy=%b required 0040/1", micro_code, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (micro_code !== 13'h0 || busy !== 1'b0 || instr_count !== 16'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: micro_code=%h busy=%b count=%0d halted=%b required 0000/0/0/0",
               micro_code, busy, instr_count, halted);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (micro_code !== 13'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: micro_code=%h busy=%b required 0000/0", micro_code, busy);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap;
    launch(4'd0);
    for (int n = 1; n <= 8; n++) begin
      repeat (4) @(negedge clk);
      if (n == 7) begin
        total++;
        if (count_w !== 3'd7 || instr_count !== 16'd7) begin
          bad++;
          $display("FAIL wrap_top: narrow=%0d wide=%0d required 7/7", count_w, instr_count);
        end
      end
    end
    total++;
    if (count_w !== 3'd0 || instr_count !== 16'd8) begin
      bad++;
      $display("FAIL wrap_zero: narrow=%0d wide=%0d required 0/8", count_w, instr_count);
    end
    total++;
    if (micro_code_w !== 13'h0020 || busy_w !== 1'b1 || halted_w !== 1'b0 || illegal_w !== 1'b0) begin
      bad++;
      $display("FAIL wrap_state: micro_code=%h busy=%b halted=%b ill=%b required 0020/1/0/0",
               micro_code_w, busy_w, halted_w, illegal_w);
    end
    $display("test_wrap done");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_opcode = 4'd0;
    test_reset();
    test_load();
    test_store_stall();
    test_add_sub();
    test_illegal();
    test_halt_jumps();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
